// File: rtl/fetch_ctrl_if.sv
// I-cache read channel between the fetch sequencer (master) and the instruction cache (slave).
interface fetch_ctrl_if;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic        icache_resp;
  logic [31:0] icache_rdata;

  modport master (output icache_read, icache_addr, input icache_resp, icache_rdata);
  modport slave  (input icache_read, icache_addr, output icache_resp, icache_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one I-cache read at a time and tags delivered
// instructions with branch IDs, stalling on queue backpressure or branch-tag exhaustion.
//
// state | meaning
// IDLE  | no request outstanding; issue when the queue and branch tags allow
// REQ   | request outstanding; the returned word is delivered to decode
// DROP  | request outstanding after a flush; the returned word is discarded
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          MAX_BR   = 4,
  parameter int          BR_ID_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ctrl_if.master       icache,
  input  logic               iq_full,
  input  logic               flush_i,
  input  logic [31:0]        redirect_pc,
  input  logic               br_resolve_i,
  output logic               load_ir,
  output logic [31:0]        instr_o,
  output logic [31:0]        pc_o,
  output logic [BR_ID_W-1:0] branch_id_o,
  output logic               fetch_stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam int               CNT_W   = $clog2(MAX_BR + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BR);

  logic [1:0]         state;
  logic [31:0]        pc;
  logic               read_q;
  logic [31:0]        addr_q;
  logic [BR_ID_W-1:0] alloc_ptr;
  logic [CNT_W-1:0]   br_count;

  logic can_issue;
  logic is_br;
  logic alloc;

  assign can_issue = !iq_full && (br_count < MAX_CNT) && !flush_i;
  assign is_br     = (icache.icache_rdata[6:0] == 7'b1100011) ||
                     (icache.icache_rdata[6:0] == 7'b1101111) ||
                     (icache.icache_rdata[6:0] == 7'b1100111);
  assign load_ir   = (state == REQ) && icache.icache_resp && !flush_i;
  assign alloc     = load_ir && is_br;

  assign icache.icache_read = read_q;
  assign icache.icache_addr = addr_q;
  assign instr_o            = icache.icache_rdata;
  assign pc_o               = addr_q;
  // Non-branch words carry the tag of the youngest branch ahead of them.
  assign branch_id_o        = alloc ? alloc_ptr : alloc_ptr - BR_ID_W'(1);
  assign fetch_stall        = (state == IDLE) && !can_issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      read_q    <= 1'b0;
      addr_q    <= 32'h0;
      alloc_ptr <= '0;
      br_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            read_q <= 1'b1;
            addr_q <= pc;
            state  <= REQ;
          end else if (flush_i) begin
            pc <= redirect_pc;
          end
        end
        REQ: begin
          if (flush_i) begin
            pc <= redirect_pc;
            if (icache.icache_resp) begin
              read_q <= 1'b0;
              state  <= IDLE;
            end else begin
              // The cache cannot take back a request, so wait it out in DROP.
              state <= DROP;
            end
          end else if (icache.icache_resp) begin
            pc     <= pc + 32'd4;
            read_q <= 1'b0;
            state  <= IDLE;
          end
        end
        DROP: begin
          if (flush_i) pc <= redirect_pc;
          if (icache.icache_resp) begin
            read_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          read_q <= 1'b0;
          state  <= IDLE;
        end
      endcase

      if (alloc) alloc_ptr <= alloc_ptr + BR_ID_W'(1);

      if (flush_i)
        br_count <= '0;
      else if (alloc && !br_resolve_i)
        br_count <= br_count + CNT_W'(1);
      else if (!alloc && br_resolve_i && (br_count != '0))
        br_count <= br_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected deliveries are queued as responses are driven
// and popped when load_ir is seen; control outputs are checked directly along the way.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iq_full;
  logic        flush_i;
  logic [31:0] redirect_pc;
  logic        br_resolve_i;
  logic        load_ir;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  branch_id_o;
  logic        fetch_stall;

  fetch_ctrl_if ic ();

  fetch_ctrl #(.RESET_PC(32'h60), .MAX_BR(4), .BR_ID_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache       (ic.master),
    .iq_full      (iq_full),
    .flush_i      (flush_i),
    .redirect_pc  (redirect_pc),
    .br_resolve_i (br_resolve_i),
    .load_ir      (load_ir),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .branch_id_o  (branch_id_o),
    .fetch_stall  (fetch_stall)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Delivery monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (load_ir) begin
      if (sb.size() == 0) begin
        chk("spurious_load", {31'd0, load_ir}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("instr_o", instr_o, e.instr);
        chk("branch_id_o", {29'd0, branch_id_o}, {29'd0, e.tag});
      end
    end
  end

  // Expects a request at addr to be outstanding now; answers it this cycle and
  // leaves the bench one cycle later with the sequencer back in IDLE.
  task automatic serve(input logic [31:0] addr, input logic [31:0] word, input logic [2:0] tag,
                       input logic resolve);
    exp_t e;
    chk("req_read", {31'd0, ic.icache_read}, 32'd1);
    chk("req_addr", ic.icache_addr, addr);
    e.pc = addr; e.instr = word; e.tag = tag;
    sb.push_back(e);
    ic.icache_resp  = 1'b1;
    ic.icache_rdata = word;
    br_resolve_i    = resolve;
    step();
    ic.icache_resp  = 1'b0;
    br_resolve_i    = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);
    chk("read_dropped", {31'd0, ic.icache_read}, 32'd0);
  endtask

  initial begin
    rst             = 1'b0;
    iq_full         = 1'b1;
    flush_i         = 1'b0;
    redirect_pc     = 32'h0;
    br_resolve_i    = 1'b0;
    ic.icache_resp  = 1'b0;
    ic.icache_rdata = NOP;
    #1;
    chk("rst_read", {31'd0, ic.icache_read}, 32'd0);
    chk("rst_addr", ic.icache_addr, 32'd0);
    chk("rst_load", {31'd0, load_ir}, 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_tag", {29'd0, branch_id_o}, 32'd7);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd1);
    step();
    step();
    rst = 1'b1;

    // Queue backpressure from reset.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("iqfull_read", {31'd0, ic.icache_read}, 32'd0);
      chk("iqfull_stall", {31'd0, fetch_stall}, 32'd1);
    end
    iq_full = 1'b0;
    #1;
    chk("release_stall", {31'd0, fetch_stall}, 32'd0);
    step();

    // Streaming fetch, one word every two cycles.
    for (int i = 0; i < 3; i++) begin
      serve(32'h60 + 32'(4 * i), NOP, 3'd7, 1'b0);
      step();
    end

    // Flush in REQ, response three cycles later lands in DROP.
    chk("pre_flush_addr", ic.icache_addr, 32'h6C);
    flush_i = 1'b1; redirect_pc = 32'h200;
    step();
    flush_i = 1'b0;
    chk("drop_read", {31'd0, ic.icache_read}, 32'd1);
    chk("drop_addr", ic.icache_addr, 32'h6C);
    step();
    step();
    ic.icache_resp = 1'b1; ic.icache_rdata = NOP;
    step();
    ic.icache_resp = 1'b0;
    chk("drop_done_read", {31'd0, ic.icache_read}, 32'd0);
    step();
    chk("redir_read", {31'd0, ic.icache_read}, 32'd1);
    chk("redir_addr", ic.icache_addr, 32'h200);

    // Flush coincident with the response: word discarded.
    flush_i = 1'b1; redirect_pc = 32'h200;
    ic.icache_resp = 1'b1; ic.icache_rdata = NOP;
    step();
    flush_i = 1'b0; ic.icache_resp = 1'b0;
    chk("coinc_read", {31'd0, ic.icache_read}, 32'd0);
    step();
    chk("coinc_addr", ic.icache_addr, 32'h200);

    // Second flush in DROP together with the response: newest redirect wins.
    flush_i = 1'b1; redirect_pc = 32'h400;
    step();
    redirect_pc = 32'h500; ic.icache_resp = 1'b1;
    step();
    flush_i = 1'b0; ic.icache_resp = 1'b0;
    chk("drop2_read", {31'd0, ic.icache_read}, 32'd0);
    step();

    // Branch tags 0..3 exhaust MAX_BR.
    for (int i = 0; i < 4; i++) begin
      serve(32'h500 + 32'(4 * i), BEQ, 3'(i), 1'b0);
      step();
    end
    chk("brfull_read", {31'd0, ic.icache_read}, 32'd0);
    chk("brfull_stall", {31'd0, fetch_stall}, 32'd1);
    step();
    chk("brfull_read2", {31'd0, ic.icache_read}, 32'd0);
    br_resolve_i = 1'b1;
    step();
    br_resolve_i = 1'b0;
    chk("resolve_stall", {31'd0, fetch_stall}, 32'd0);
    step();
    // Allocate and resolve together at count 3: count stays 3, so one more branch fits.
    serve(32'h510, BEQ, 3'd4, 1'b1);
    step();
    serve(32'h514, BEQ, 3'd5, 1'b0);
    step();
    chk("brfull2_stall", {31'd0, fetch_stall}, 32'd1);

    // Flush clears the count; tags carry on from alloc_ptr and wrap.
    flush_i = 1'b1; redirect_pc = 32'h600;
    step();
    flush_i = 1'b0;
    chk("flush_idle_read", {31'd0, ic.icache_read}, 32'd0);
    step();
    serve(32'h600, BEQ, 3'd6, 1'b0);
    step();
    serve(32'h604, JAL, 3'd7, 1'b0);
    step();
    serve(32'h608, JALR, 3'd0, 1'b0);
    step();
    serve(32'h60C, NOP, 3'd0, 1'b0);
    step();

    // Asynchronous reset mid-request, then a stale response.
    chk("pre_rst_read", {31'd0, ic.icache_read}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_read", {31'd0, ic.icache_read}, 32'd0);
    chk("arst_addr", ic.icache_addr, 32'd0);
    chk("arst_tag", {29'd0, branch_id_o}, 32'd7);
    step();
    rst = 1'b1;
    ic.icache_resp = 1'b1; ic.icache_rdata = BEQ;
    #1;
    chk("stale_load", {31'd0, load_ir}, 32'd0);
    step();
    ic.icache_resp = 1'b0;
    serve(32'h60, NOP, 3'd7, 1'b0);
    step();

    chk("sb_final", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
